// File: rtl/writeback_stage_pkg.sv
// writeback_stage_pkg: shared widths and encodings for the writeback stage.
package writeback_stage_pkg;
    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;
    typedef enum logic [1:0] {WB_ALU = 2'b00, WB_MEM = 2'b01, WB_LINK = 2'b10} wb_sel_e;
    typedef enum logic [1:0] {LD_B = 2'b00, LD_H = 2'b01, LD_W = 2'b10} ld_size_e;
endpackage

// File: rtl/writeback_stage_load_extend.sv
// load_extend: selects the byte/halfword lane of a loaded word and zero- or sign-extends it.
module load_extend
    import writeback_stage_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W
) (
    input  logic [DATA_W-1:0] mem_data,
    input  logic [1:0]        ld_size,
    input  logic              ld_signed,
    input  logic [1:0]        addr_lo,
    output logic [DATA_W-1:0] data_out
);
    logic [7:0]  b;
    logic [15:0] h;
    assign b = mem_data[{addr_lo, 3'b000} +: 8];
    assign h = mem_data[{addr_lo[1], 4'b0000} +: 16];
    always_comb begin
        data_out = ld_size == LD_B ? {{(DATA_W-8){ld_signed & b[7]}}, b} :
                   ld_size == LD_H ? {{(DATA_W-16){ld_signed & h[15]}}, h} : mem_data;
    end
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: registers the MEM-stage result and drives the register-file write port.
// Optional WB_BYPASS_EN adds combinational forwarding of the write port to two read ports.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] link_pc,
    input  logic [ADDR_W-1:0] rd,
    input  logic              rf_le_in,
    input  logic [1:0]        wb_sel,
    input  logic [1:0]        ld_size,
    input  logic              ld_signed,
    input  logic [1:0]        addr_lo,
    output logic [DATA_W-1:0] PW,
    output logic [ADDR_W-1:0] RW,
    output logic              LE,
    output logic              wb_valid
`ifdef WB_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    input  logic [DATA_W-1:0] PA_rf,
    input  logic [DATA_W-1:0] PB_rf,
    output logic [DATA_W-1:0] PA_fwd,
    output logic [DATA_W-1:0] PB_fwd
`endif
);
    logic [DATA_W-1:0] alu_q, mem_q, link_q, ext;
    logic [ADDR_W-1:0] rd_q;
    logic              le_q, signed_q, valid_q;
    logic [1:0]        sel_q, size_q, lo_q;
    // A bubble is the all-zero entry, so flush and reset share one clear path.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            alu_q    <= '0;
            mem_q    <= '0;
            link_q   <= '0;
            rd_q     <= '0;
            le_q     <= 1'b0;
            sel_q    <= 2'b00;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            lo_q     <= 2'b00;
            valid_q  <= 1'b0;
        end else if (!stall) begin
            alu_q    <= alu_result;
            mem_q    <= mem_data;
            link_q   <= link_pc;
            rd_q     <= rd;
            le_q     <= rf_le_in;
            sel_q    <= wb_sel;
            size_q   <= ld_size;
            signed_q <= ld_signed;
            lo_q     <= addr_lo;
            valid_q  <= 1'b1;
        end
    end
    load_extend #(.DATA_W(DATA_W)) u_ext (
        .mem_data (mem_q),
        .ld_size  (size_q),
        .ld_signed(signed_q),
        .addr_lo  (lo_q),
        .data_out (ext)
    );
    always_comb begin
        PW = sel_q == WB_ALU  ? alu_q :
             sel_q == WB_MEM  ? ext :
             sel_q == WB_LINK ? link_q : '0;
    end
    assign RW       = rd_q;
    assign wb_valid = valid_q;
    assign LE       = valid_q & le_q & (rd_q != '0) & (sel_q != 2'b11);
`ifdef WB_BYPASS_EN
    assign PA_fwd = (LE && RW == RA) ? PW : PA_rf;
    assign PB_fwd = (LE && RW == RB) ? PW : PB_rf;
`endif
endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter: DATA_W, 32, datapath width.
REQ-002 Parameter: ADDR_W, 5, register address width (32 registers).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 stall  in  1  hold the stage register.
REQ-006 flush  in  1  replace the captured entry with a bubble.
REQ-007 alu_result  in  DATA_W  ALU result from the MEM stage.
REQ-008 mem_data  in  DATA_W  raw 32-bit word from data memory.
REQ-009 link_pc  in  DATA_W  return address for link instructions.
REQ-010 rd  in  ADDR_W  destination register.
REQ-011 rf_le_in  in  1  instruction writes the register file.
REQ-012 wb_sel  in  2  source: 00 alu, 01 memory, 10 link_pc, 11 reserved.
REQ-013 ld_size  in  2  00 byte, 01 halfword, 10 word; 11 treated as word.
REQ-014 ld_signed  in  1  sign-extend sub-word loads when 1.
REQ-015 addr_lo  in  2  alu_result[1:0] of the load address, for lane selection.
REQ-016 PW  out  DATA_W  write data to the register file.
REQ-017 RW  out  ADDR_W  write address to the register file.
REQ-018 LE  out  1  register file load enable.
REQ-019 wb_valid  out  1  stage holds a real instruction, not a bubble.

Function
REQ-020 Capture all inputs on each rising clk when reset=0, flush=0 and stall=0; PW/RW/LE reflect the captured entry in the following cycle, so the register file writes one edge after capture.
REQ-021 Priority at the edge: reset > flush > stall > capture.
REQ-022 flush=1 loads a bubble: wb_valid=0 and LE=0, with RW and PW driven to 0.
REQ-023 stall=1 holds every stored field, so LE is reasserted each cycle (an idempotent rewrite).
REQ-024 LE = wb_valid & stored rf_le_in & (RW != 0); register 0 is never written.
REQ-025 Data mux: wb_sel 00 selects alu_result; 01 selects the load-extended mem_data; 10 selects link_pc; 11 drives PW=0 and forces LE=0.
REQ-026 Byte loads: lane = addr_lo (0 selects bits 7:0, 3 selects bits 31:24), then zero- or sign-extend to DATA_W.
REQ-027 Halfword loads: lane = addr_lo[1] (0 selects bits 15:0), then extend; addr_lo[0] is ignored.
REQ-028 Word loads pass mem_data unchanged; ld_signed is ignored.
REQ-029 Load extension is applied to the registered mem_data, not in the capture path.

Reset
REQ-030 While reset=1 at an edge: wb_valid=0, LE=0, RW=0, PW=0, and all stored fields are cleared.
REQ-031 A reset asserted while stall=1 still clears the stage; any pending write is discarded.

Configuration
REQ-032 WB_BYPASS_EN defined: add inputs RA, RB (ADDR_W) and PA_rf, PB_rf (DATA_W), and outputs PA_fwd, PB_fwd (DATA_W).
REQ-033 With bypass enabled, PA_fwd = PW when LE=1 and RW==RA, otherwise PA_rf; PB_fwd is formed the same way; the forward is combinational within the same cycle.
REQ-034 WB_BYPASS_EN undefined: these ports are absent and there is no bypass logic.

Structure
REQ-035 A shared package holds the DATA_W and ADDR_W defaults, the wb_sel encodings (WB_ALU, WB_MEM, WB_LINK) and the ld_size encodings (LD_B, LD_H, LD_W).
REQ-036 The load extender is a separate combinational sub-module, load_extend, with ports mem_data, ld_size, ld_signed, addr_lo and data_out.

Verification
REQ-037 Apply reset for 2 cycles, then release -> LE=0, PW=0, RW=0, wb_valid=0 until the first capture.
REQ-038 Capture alu_result=20, rd=5, wb_sel=00, rf_le_in=1 -> next cycle PW=20, RW=5, LE=1; a register file instance reads 20 from register 5 after the following edge.
REQ-039 Byte load: mem_data=0x80FF7F01, ld_size=00, addr_lo=3.
  - ld_signed=1 -> PW=0xFFFFFF80.
  - Same stimulus with ld_signed=0 -> PW=0x00000080.
  - Halfword load, addr_lo=2, ld_signed=1 -> PW=0xFFFF80FF.
REQ-040 rd=0 with rf_le_in=1 and alu_result=99 -> LE=0; register 0 still reads 0.
REQ-041 Capture rd=7, then assert stall=1 and flush=1 in the same cycle -> bubble: LE=0, wb_valid=0 (flush wins over stall).
REQ-042 With WB_BYPASS_EN defined: LE=1, RW=9, PW=0x1234, RA=9, PA_rf=0 -> PA_fwd=0x1234.
  - RB=8, PB_rf=0x55 -> PB_fwd=0x55.
